// File: rtl/inst_fetch_buffer.sv
// Dual-issue instruction queue between fetch and decode.
// Circular buffer of {pc, inst} entries. It accepts up to two words per cycle,
// presents up to two entries per cycle (first-word fall-through), and empties
// on a front-end redirect (flush).
module inst_fetch_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid1,
    input  logic             in_valid2,
    input  logic [31:0]      in_pc1,
    input  logic [31:0]      in_inst1,
    input  logic [31:0]      in_pc2,
    input  logic [31:0]      in_inst2,
    input  logic             read_en1,
    input  logic             read_en2,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_inst1,
    output logic [31:0]      out_pc2,
    output logic [31:0]      out_inst2,
    output logic             almost_full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   AF_LIM  = (PTR_W + 1)'(DEPTH - 2);

    entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [PTR_W-1:0] rd_ptr_nx, wr_ptr_nx;
    logic             wr_ok, wr1, wr2, rd1, rd2;
    logic [1:0]       n_wr, n_rd;
    entry_t           head1, head2;

    // Second-slot indices wrap naturally, since the pointers are PTR_W bits wide.
    assign rd_ptr_nx = rd_ptr_q + PTR_ONE;
    assign wr_ptr_nx = wr_ptr_q + PTR_ONE;

    // Status is derived from registered occupancy only.
    assign almost_full = (count_q > AF_LIM);
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign out_valid1  = (count_q != '0);
    assign out_valid2  = (count_q > (PTR_W + 1)'(1));

    // Accept logic. in_valid2 is only honoured behind an accepted slot 1, and
    // a second read is only honoured behind an accepted first read.
    assign wr_ok = ~almost_full & ~flush;
    assign wr1   = in_valid1 & wr_ok;
    assign wr2   = wr1 & in_valid2;
    assign rd1   = read_en1 & out_valid1 & ~flush;
    assign rd2   = rd1 & read_en2 & out_valid2;
    assign n_wr  = {1'b0, wr1} + {1'b0, wr2};
    assign n_rd  = {1'b0, rd1} + {1'b0, rd2};

    // Fall-through read ports; invalid slots are forced to zero.
    always_comb begin
        head1     = mem_q[rd_ptr_q];
        head2     = mem_q[rd_ptr_nx];
        out_pc1   = out_valid1 ? head1.pc   : 32'h0;
        out_inst1 = out_valid1 ? head1.inst : 32'h0;
        out_pc2   = out_valid2 ? head2.pc   : 32'h0;
        out_inst2 = out_valid2 ? head2.inst : 32'h0;
    end

    // Next-state pointers and occupancy. Flush discards same-cycle traffic.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(n_rd);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
        count_d  = count_q + (PTR_W + 1)'(n_wr) - (PTR_W + 1)'(n_rd);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control registers; reset takes priority over flush and all traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage writes; the contents themselves are never reset.
    always_ff @(posedge clk) begin
        if (!rst && wr1) mem_q[wr_ptr_q]  <= '{pc: in_pc1, inst: in_inst1};
        if (!rst && wr2) mem_q[wr_ptr_nx] <= '{pc: in_pc2, inst: in_inst2};
    end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Dual-issue instruction queue between instruction fetch and decode.
- Accepts up to two instruction words per cycle from the fetch stage, stores them as {pc, inst} entries in a circular buffer, and presents up to two entries per cycle to decode.
- Drives the back-pressure used as the fetch-stage stall.
- Discards all contents on a front-end redirect: exception, branch mispredict or jump.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  redirect; empties the buffer
- in_valid1  in  1  fetch slot 1 word valid
- in_valid2  in  1  fetch slot 2 word valid
- in_pc1  in  32  PC of slot 1
- in_inst1  in  32  instruction of slot 1
- in_pc2  in  32  PC of slot 2
- in_inst2  in  32  instruction of slot 2
- read_en1  in  1  decode consumes head entry
- read_en2  in  1  decode consumes second entry
- out_valid1  out  1  head entry present
- out_valid2  out  1  second entry present
- out_pc1  out  32  head PC
- out_inst1  out  32  head instruction
- out_pc2  out  32  second PC
- out_inst2  out  32  second instruction
- almost_full  out  1  fewer than 2 free entries; drives fetch stall
- empty  out  1  count == 0
- count  out  PTR_W+1  current occupancy

Behaviour:
State
- Storage array of DEPTH {pc, inst} entries.
- Registers: rd_ptr, wr_ptr (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits).

Reset (rst=1 at posedge)
- rd_ptr=0, wr_ptr=0, count=0.
- Outputs next cycle: out_valid1=0, out_valid2=0, empty=1, almost_full=0, count=0.
- Storage contents are not reset.
- rst has priority over flush and all other inputs.

Outputs (combinational from registered state, first-word fall-through)
- out_valid1 = (count>=1); out_valid2 = (count>=2).
- out_pc1/out_inst1 = entry[rd_ptr]; out_pc2/out_inst2 = entry[rd_ptr+1 mod DEPTH].
- Any out_pc/out_inst whose valid is 0 is forced to 32'h0.
- almost_full = (count > DEPTH-2); empty = (count==0).

Write accept (evaluated against count at cycle start)
- wr_ok = ~almost_full & ~flush.
- in_valid1 & in_valid2 & wr_ok: slot1 written at wr_ptr, slot2 at wr_ptr+1; wr_ptr += 2.
- in_valid1 & ~in_valid2 & wr_ok: slot1 written at wr_ptr; wr_ptr += 1.
- in_valid2 without in_valid1 is illegal and ignored; nothing is written.
- Writes while almost_full=1 are dropped silently; fetch must be stalled by almost_full.

Read accept
- rd1 = read_en1 & out_valid1 & ~flush.
- rd2 = rd1 & read_en2 & out_valid2.
- read_en2 without an accepted rd1 is ignored (in-order consumption).
- rd_ptr += rd1 + rd2.

Occupancy and latency
- count_next = count + writes − reads; simultaneous read and write in the same cycle are both honoured.
- No bypass: a word written in cycle N is visible at the outputs in cycle N+1 (1-cycle latency).
- A read in cycle N removes the entry; new head is visible in cycle N+1.

Flush
- flush=1 at posedge: rd_ptr=0, wr_ptr=0, count=0.
- Same-cycle writes and reads are discarded.
- out_valid1=0 in the next cycle.
- Entries fetched at the redirect target may be written from the cycle after flush.

Wrap-around
- Pointer arithmetic is modulo DEPTH.
- A pair write at wr_ptr=DEPTH-1 places slot2 at index 0.
- out_pc2 at rd_ptr=DEPTH-1 reads index 0.

Invariants
- count ≤ DEPTH at all times.
- FIFO order is preserved, slot1 ahead of slot2.

Test Plan:
- Reset: rst=1 for 2 cycles → empty=1, count=0, out_valid1=0, out_valid2=0, out_pc1=0, almost_full=0.
- Pair write then pair read:
  - Cycle 1: in_valid1=in_valid2=1, pc 0xbfc00000/0xbfc00004, inst 0x11111111/0x22222222.
  - Cycle 2: out_valid1=out_valid2=1 with those values, count=2.
  - Assert read_en1=read_en2=1 → cycle 3: empty=1.
- Fill/back-pressure (DEPTH=16):
  - 7 pair writes → count=14, almost_full=0.
  - 1 single write → count=15, almost_full=1.
  - A further pair write → count stays 15, contents unchanged.
  - One read → count=14, almost_full=0.
- Wrap-around:
  - Stream 40 sequential PCs starting 0xbfc00000 as pairs; read 1 or 2 per cycle in a pseudo-random pattern, never overflowing.
  - Output PCs strictly increase by 4, no loss or duplication across the index 15→0 wrap.
- Flush priority:
  - With count=6, assert flush together with a pair write and read_en1=read_en2=1 → next cycle count=0, empty=1.
  - A subsequent write of pc 0xbfc00380 appears as out_pc1 one cycle later.
- Partial/illegal reads and writes:
  - count=3, read_en1=1 only → count=2, head advances by one entry.
  - read_en2=1 with read_en1=0 → no change.
  - in_valid2=1 with in_valid1=0 → count unchanged.
